// File: rtl/monotonize_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : monotonize_arbiter_if
// Description : Request/result bundle for the monotonize arbiter. The
//               requester side (master) drives the request vectors. The
//               arbiter side (slave) returns grants, tagged results and
//               status.
// Revision    : 1.0 - initial release
// ============================================================================
interface monotonize_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_dir;
    logic [NUM_REQ*128-1:0] req_data;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   out_valid;
    logic [ID_W-1:0]        out_id;
    logic                   out_dir;
    logic [127:0]           out_data;
    logic                   busy;
    logic [31:0]            issue_count;

    modport master (
        output req_valid, req_dir, req_data,
        input  req_ready, out_valid, out_id, out_dir, out_data, busy, issue_count
    );

    modport slave (
        input  req_valid, req_dir, req_data,
        output req_ready, out_valid, out_id, out_dir, out_data, busy, issue_count
    );
endinterface
`default_nettype wire

// File: rtl/monotonize_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : monotonize_arbiter
// Description : Round-robin scheduler that shares a 1-stage up-monotonizer and
//               a 2-stage down-monotonizer among NUM_REQ requesters. Results
//               return on one registered, tagged bus. An up request whose
//               turn comes right after a down acceptance gets one bubble, so
//               the two cores never finish on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module monotonize_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  wire                    clk,
    input  wire                    rst,
    monotonize_arbiter_if.slave    bus
);

    localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // ------------------------------------------------------------------
    // Subset-sum (zeta) transforms over the 7-bit index of a 128-entry
    // truth table. Each pass over bit b merges a pair of entries that
    // differ only in bit b. Passes lo..hi may be split across stages.
    // ------------------------------------------------------------------
    function automatic logic [127:0] f_zeta_up(input logic [127:0] x,
                                               input int lo, input int hi);
        logic [127:0] r;
        logic [6:0]   jj;
        logic [6:0]   msk;
        r = x;
        for (int b = lo; b <= hi; b++) begin
            msk = 7'd1 << b;
            for (int j = 0; j < 128; j++) begin
                jj = 7'(j);
                // Entry with bit b set absorbs its partner with bit b clear.
                if ((jj & msk) != 7'd0) begin
                    r[jj] = r[jj] | r[jj & ~msk];
                end
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] f_zeta_down(input logic [127:0] x,
                                                 input int lo, input int hi);
        logic [127:0] r;
        logic [6:0]   jj;
        logic [6:0]   msk;
        r = x;
        for (int b = lo; b <= hi; b++) begin
            msk = 7'd1 << b;
            for (int j = 0; j < 128; j++) begin
                jj = 7'(j);
                // Entry with bit b clear absorbs its partner with bit b set.
                if ((jj & msk) == 7'd0) begin
                    r[jj] = r[jj] | r[jj | msk];
                end
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_ptr_w-1:0] rr_ptr_q,      rr_ptr_d;
    logic               down_last_q,   down_last_d;
    logic [31:0]        issue_count_q, issue_count_d;

    logic               up_vld_q,  up_vld_d;
    logic [ID_W-1:0]    up_id_q,   up_id_d;
    logic [127:0]       up_data_q, up_data_d;

    logic               dn1_vld_q,  dn1_vld_d;
    logic [ID_W-1:0]    dn1_id_q,   dn1_id_d;
    logic [127:0]       dn1_data_q, dn1_data_d;

    logic               dn2_vld_q,  dn2_vld_d;
    logic [ID_W-1:0]    dn2_id_q,   dn2_id_d;
    logic [127:0]       dn2_data_q, dn2_data_d;

    logic               out_valid_q, out_valid_d;
    logic [ID_W-1:0]    out_id_q,    out_id_d;
    logic               out_dir_q,   out_dir_d;
    logic [127:0]       out_data_q,  out_data_d;

    // ------------------------------------------------------------------
    // Arbitration wires
    // ------------------------------------------------------------------
    logic               w_cand_found;
    logic [c_ptr_w-1:0] w_cand;
    logic               w_cand_dir;
    logic [127:0]       w_gnt_data;
    logic [NUM_REQ-1:0] w_ready;
    logic               w_accept;

    // Pick the first valid requester at or after rr_ptr and decide whether it
    // may be granted this cycle (an up right after a down must wait one).
    always_comb begin : p_arbiter
        int idx;
        w_cand_found = 1'b0;
        w_cand       = '0;
        w_ready      = '0;
        idx          = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_cand_found && bus.req_valid[idx]) begin
                w_cand_found = 1'b1;
                w_cand       = c_ptr_w'(idx);
            end
        end
        w_cand_dir = bus.req_dir[w_cand];
        w_gnt_data = bus.req_data[128*int'(w_cand) +: 128];
        if (!rst && w_cand_found && !(!w_cand_dir && down_last_q)) begin
            w_ready[w_cand] = 1'b1;
        end
        w_accept = |(bus.req_valid & w_ready);
    end

    // Next-state for pointer, collision flag, counter, tag pipes and output.
    always_comb begin : p_next
        rr_ptr_d      = rr_ptr_q;
        issue_count_d = issue_count_q;
        down_last_d   = w_accept && w_cand_dir;

        if (w_accept) begin
            issue_count_d = issue_count_q + 32'd1;
            if (int'(w_cand) == NUM_REQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = w_cand + c_ptr_w'(1);
            end
        end

        up_vld_d  = w_accept && !w_cand_dir;
        up_id_d   = ID_W'(w_cand);
        dn1_vld_d = w_accept && w_cand_dir;
        dn1_id_d  = ID_W'(w_cand);
        dn2_vld_d = dn1_vld_q;
        dn2_id_d  = dn1_id_q;

        // The bubble rule guarantees at most one final stage is valid.
        out_valid_d = 1'b0;
        out_id_d    = out_id_q;
        out_dir_d   = out_dir_q;
        out_data_d  = out_data_q;
        if (dn2_vld_q) begin
            out_valid_d = 1'b1;
            out_id_d    = dn2_id_q;
            out_dir_d   = 1'b1;
            out_data_d  = dn2_data_q;
        end else if (up_vld_q) begin
            out_valid_d = 1'b1;
            out_id_d    = up_id_q;
            out_dir_d   = 1'b0;
            out_data_d  = up_data_q;
        end
    end

    // Core datapaths: granted data feeds both cores every cycle; the tag
    // pipes decide which result is real. Down work is split 4 + 3 passes.
    always_comb begin : p_cores
        up_data_d  = f_zeta_up(w_gnt_data, 0, 6);
        dn1_data_d = f_zeta_down(w_gnt_data, 0, 3);
        dn2_data_d = f_zeta_down(dn1_data_q, 4, 6);
    end

    // Control and output registers, cleared immediately on reset.
    always_ff @(posedge clk or posedge rst) begin : p_ctrl_regs
        if (rst) begin
            rr_ptr_q      <= '0;
            down_last_q   <= 1'b0;
            issue_count_q <= 32'd0;
            up_vld_q      <= 1'b0;
            up_id_q       <= '0;
            dn1_vld_q     <= 1'b0;
            dn1_id_q      <= '0;
            dn2_vld_q     <= 1'b0;
            dn2_id_q      <= '0;
            out_valid_q   <= 1'b0;
            out_id_q      <= '0;
            out_dir_q     <= 1'b0;
            out_data_q    <= 128'd0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            down_last_q   <= down_last_d;
            issue_count_q <= issue_count_d;
            up_vld_q      <= up_vld_d;
            up_id_q       <= up_id_d;
            dn1_vld_q     <= dn1_vld_d;
            dn1_id_q      <= dn1_id_d;
            dn2_vld_q     <= dn2_vld_d;
            dn2_id_q      <= dn2_id_d;
            out_valid_q   <= out_valid_d;
            out_id_q      <= out_id_d;
            out_dir_q     <= out_dir_d;
            out_data_q    <= out_data_d;
        end
    end

    // Core data registers carry no reset; their contents are qualified by tags.
    always_ff @(posedge clk) begin : p_data_regs
        up_data_q  <= up_data_d;
        dn1_data_q <= dn1_data_d;
        dn2_data_q <= dn2_data_d;
    end

    assign bus.req_ready   = w_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_id      = out_id_q;
    assign bus.out_dir     = out_dir_q;
    assign bus.out_data    = out_data_q;
    assign bus.issue_count = issue_count_q;
    assign bus.busy        = up_vld_q | dn1_vld_q | dn2_vld_q | out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_monotonize_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_monotonize_arbiter
// Description : Directed self-checking bench for monotonize_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_monotonize_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    localparam logic [127:0] c_ones = {128{1'b1}};
    localparam logic [127:0] c_b0   = 128'h1;
    localparam logic [127:0] c_b5   = 128'h20;
    localparam logic [127:0] c_b127 = {1'b1, 127'd0};
    localparam logic [127:0] c_up5  = {16{8'hA0}};   // indices j with j&5==5
    localparam logic [127:0] c_dn5  = 128'h33;       // indices 0,1,4,5

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    monotonize_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    monotonize_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one request and watch the result bus for six cycles.
    task automatic issue_capture(input int id, input logic dir, input logic [127:0] data,
                                 output bit granted, output int lat, output int pulses,
                                 output logic [ID_W-1:0] oid, output logic odir,
                                 output logic [127:0] odata);
        granted = 1'b0; lat = 0; pulses = 0; oid = '0; odir = 1'b0; odata = '0;
        @(negedge clk);
        bus.req_dir[id] = dir;
        bus.req_data[id*128 +: 128] = data;
        bus.req_valid[id] = 1'b1;
        for (int w = 0; w < 8 && !granted; w++) begin
            #1;
            if (bus.req_ready[id] === 1'b1) granted = 1'b1;
            else @(negedge clk);
        end
        if (granted) begin
            @(posedge clk);
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                if (k == 1) bus.req_valid[id] = 1'b0;
                if (bus.out_valid === 1'b1) begin
                    pulses++;
                    if (lat == 0) begin
                        lat = k; oid = bus.out_id; odir = bus.out_dir; odata = bus.out_data;
                    end
                end
            end
        end else begin
            bus.req_valid[id] = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_dir   = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
            n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
            n_cmp++; if (bus.issue_count !== 32'd0) begin n_fail++; $display("FAIL reset_issue_count: got %0d want 0", bus.issue_count); end
            n_cmp++; if (bus.out_data !== 128'd0 || bus.out_id !== '0 || bus.out_dir !== 1'b0) begin
                n_fail++; $display("FAIL reset_out_regs: got id %0d dir %b data %h want all zero", bus.out_id, bus.out_dir, bus.out_data);
            end
            @(negedge clk);
        end
        bus.req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_single_up();
        bit g; int lat, p; logic [ID_W-1:0] oid; logic odir; logic [127:0] od;
        issue_capture(1, 1'b0, c_b0, g, lat, p, oid, odir, od);
        n_cmp++; if (g !== 1'b1) begin n_fail++; $display("FAIL up_grant: got %b want 1", g); end
        n_cmp++; if (lat != 2 || p != 1) begin n_fail++; $display("FAIL up_latency: got lat %0d pulses %0d want 2/1", lat, p); end
        n_cmp++; if (oid !== 2'd1 || odir !== 1'b0) begin n_fail++; $display("FAIL up_tag: got id %0d dir %b want 1/0", oid, odir); end
        n_cmp++; if (od !== c_ones) begin n_fail++; $display("FAIL up_data: got %h want %h", od, c_ones); end
        n_cmp++; if (bus.issue_count !== 32'd1) begin n_fail++; $display("FAIL up_issue_count: got %0d want 1", bus.issue_count); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL up_busy_drain: got %b want 0", bus.busy); end
    endtask

    task automatic test_single_down();
        bit g; int lat, p; logic [ID_W-1:0] oid; logic odir; logic [127:0] od;
        issue_capture(2, 1'b1, c_b0, g, lat, p, oid, odir, od);
        n_cmp++; if (lat != 3 || p != 1) begin n_fail++; $display("FAIL down_latency: got lat %0d pulses %0d want 3/1", lat, p); end
        n_cmp++; if (oid !== 2'd2 || odir !== 1'b1) begin n_fail++; $display("FAIL down_tag: got id %0d dir %b want 2/1", oid, odir); end
        n_cmp++; if (od !== c_b0) begin n_fail++; $display("FAIL down_data_b0: got %h want %h", od, c_b0); end
        issue_capture(2, 1'b1, c_b127, g, lat, p, oid, odir, od);
        n_cmp++; if (lat != 3 || od !== c_ones) begin n_fail++; $display("FAIL down_data_b127: got lat %0d data %h want 3/%h", lat, od, c_ones); end
        n_cmp++; if (bus.issue_count !== 32'd3) begin n_fail++; $display("FAIL down_issue_count: got %0d want 3", bus.issue_count); end
    endtask

    task automatic test_bit5();
        bit g; int lat, p; logic [ID_W-1:0] oid; logic odir; logic [127:0] od;
        issue_capture(0, 1'b0, c_b5, g, lat, p, oid, odir, od);
        n_cmp++; if (od !== c_up5) begin n_fail++; $display("FAIL up5_data: got %h want %h", od, c_up5); end
        n_cmp++; if ($countones(od) != 32 || od[0] !== 1'b0 || od[127] !== 1'b1) begin
            n_fail++; $display("FAIL up5_shape: got ones %0d bit0 %b bit127 %b want 32/0/1", $countones(od), od[0], od[127]);
        end
        n_cmp++; if (oid !== 2'd0 || lat != 2) begin n_fail++; $display("FAIL up5_tag: got id %0d lat %0d want 0/2", oid, lat); end
        issue_capture(3, 1'b1, c_b5, g, lat, p, oid, odir, od);
        n_cmp++; if (od !== c_dn5 || oid !== 2'd3 || lat != 3) begin
            n_fail++; $display("FAIL down5: got data %h id %0d lat %0d want %h/3/3", od, oid, lat, c_dn5);
        end
    endtask

    task automatic test_down_then_up();
        logic [3:0] exp_rdy [0:7] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0] gnt;
        do_reset();
        @(negedge clk);
        bus.req_dir = 4'b0001;
        bus.req_data[0 +: 128]   = c_b127;
        bus.req_data[128 +: 128] = c_b0;
        bus.req_valid = 4'b0011;
        for (int k = 0; k < 8; k++) begin
            #1;
            gnt = bus.req_ready;
            n_cmp++; if (gnt !== exp_rdy[k]) begin n_fail++; $display("FAIL dtu_ready[%0d]: got %b want %b", k, gnt, exp_rdy[k]); end
            n_cmp++;
            if (k == 3) begin
                if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd0 || bus.out_dir !== 1'b1 || bus.out_data !== c_ones) begin
                    n_fail++; $display("FAIL dtu_out[3]: got v%b id%0d dir%b %h want v1 id0 dir1 ones", bus.out_valid, bus.out_id, bus.out_dir, bus.out_data);
                end
            end else if (k == 4) begin
                if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd1 || bus.out_dir !== 1'b0 || bus.out_data !== c_ones) begin
                    n_fail++; $display("FAIL dtu_out[4]: got v%b id%0d dir%b %h want v1 id1 dir0 ones", bus.out_valid, bus.out_id, bus.out_dir, bus.out_data);
                end
            end else if (bus.out_valid !== 1'b0) begin
                n_fail++; $display("FAIL dtu_out[%0d]: got valid %b want 0", k, bus.out_valid);
            end
            @(posedge clk);
            @(negedge clk);
            bus.req_valid = bus.req_valid & ~gnt;
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]   pat [0:5] = '{4'b0001, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b1000};
        logic [127:0] exp_data [0:3] = '{c_dn5, c_up5, c_ones, c_ones};
        int cnt [0:3] = '{0, 0, 0, 0};
        int id;
        do_reset();
        @(negedge clk);
        bus.req_dir = 4'b0101;
        bus.req_data[0 +: 128]   = c_b5;
        bus.req_data[128 +: 128] = c_b5;
        bus.req_data[256 +: 128] = c_b127;
        bus.req_data[384 +: 128] = c_b0;
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 102; k++) begin
            if (k == 96) bus.req_valid = 4'b0000;
            #1;
            if (k < 96) begin
                n_cmp++; if (bus.req_ready !== pat[k % 6]) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", k, bus.req_ready, pat[k % 6]); end
            end
            if (bus.out_valid === 1'b1) begin
                id = int'(bus.out_id);
                cnt[id]++;
                n_cmp++;
                if (bus.out_dir !== ((id % 2) == 0) || bus.out_data !== exp_data[id]) begin
                    n_fail++; $display("FAIL rr_result[%0d]: id %0d got dir %b data %h want dir %b data %h", k, id, bus.out_dir, bus.out_data, (id % 2) == 0, exp_data[id]);
                end
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (cnt[i] != 16) begin n_fail++; $display("FAIL rr_count[%0d]: got %0d want 16", i, cnt[i]); end
        end
        n_cmp++; if (bus.issue_count !== 32'd64) begin n_fail++; $display("FAIL rr_issue_count: got %0d want 64", bus.issue_count); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rr_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_midflight();
        bit g; int lat, p; logic [ID_W-1:0] oid; logic odir; logic [127:0] od;
        int stray;
        stray = 0;
        @(negedge clk);
        bus.req_dir = 4'b0001;
        bus.req_data[0 +: 128]   = c_b0;
        bus.req_data[128 +: 128] = c_b0;
        bus.req_valid = 4'b0011;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant: got %b want 0001", bus.req_ready); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (bus.out_valid !== 1'b0) stray++;
            if (c == 1) begin
                n_cmp++; if (bus.busy !== 1'b0 || bus.issue_count !== 32'd0) begin
                    n_fail++; $display("FAIL mid_reset_state: got busy %b count %0d want 0/0", bus.busy, bus.issue_count);
                end
            end
            @(negedge clk);
            if (c == 1) rst = 1'b0;
        end
        n_cmp++; if (stray != 0) begin n_fail++; $display("FAIL mid_no_pulse: got %0d pulses want 0", stray); end
        n_cmp++; if (bus.busy !== 1'b0 || bus.issue_count !== 32'd0) begin
            n_fail++; $display("FAIL mid_after_state: got busy %b count %0d want 0/0", bus.busy, bus.issue_count);
        end
        bus.req_valid = 4'b1001;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_rr_ptr: got %b want 0001", bus.req_ready); end
        bus.req_valid = 4'b0000;
        issue_capture(1, 1'b0, c_b0, g, lat, p, oid, odir, od);
        n_cmp++; if (lat != 2 || p != 1 || oid !== 2'd1 || od !== c_ones) begin
            n_fail++; $display("FAIL mid_next_up: got lat %0d pulses %0d id %0d data %h want 2/1/1/ones", lat, p, oid, od);
        end
        n_cmp++; if (bus.issue_count !== 32'd1) begin n_fail++; $display("FAIL mid_issue_count: got %0d want 1", bus.issue_count); end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_dir   = '0;
        bus.req_data  = '0;
        test_reset();
        test_single_up();
        test_single_down();
        test_bit5();
        test_down_then_up();
        test_round_robin();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/monotonize_arbiter.md
# monotonize_arbiter

Round-robin scheduler that shares one pipelined up-monotonizer (1-cycle core latency) and one pipelined down-monotonizer (2-cycle core latency) among NUM_REQ requesters. Each request carries a 128-bit function and a direction bit. Results return on a single registered, tagged result bus. The arbiter prevents up and down results from colliding on that bus by inserting bubbles, and it keeps grant order strictly round-robin so no requester starves.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- ID_W, 2, requester tag width, must be ≥ clog2(NUM_REQ)
- clk  in  1  single clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  request pending per requester; must not depend on req_ready
- req_dir  in  NUM_REQ  per requester: 0 = monotonize up, 1 = monotonize down
- req_data  in  NUM_REQ*128  per requester function; slice i is bits [128*i+127:128*i]
- req_ready  out  NUM_REQ  one-hot-or-zero grant; combinational from req_valid/req_dir/state
- out_valid  out  1  result valid, single-cycle pulse per request, no backpressure
- out_id  out  ID_W  index of requester that issued the result
- out_dir  out  1  direction of the result
- out_data  out  128  monotonized function
- busy  out  1  any request in flight
- issue_count  out  32  total accepted requests, wraps mod 2^32

## Operation
- Acceptance: requester i is accepted on a posedge where req_valid[i] & req_ready[i]. At most one acceptance per cycle.
- Routing: the granted req_data is driven straight into both cores. Only the core matching req_dir is tagged valid.
- Per-core tag pipelines:
  - Up core: 1 stage holding {valid, id}.
  - Down core: 2 stages holding {valid, id}.
  - Output register captures whichever core's final stage is valid and loads out_valid/out_id/out_dir/out_data.
- Collision rule: a down issued in cycle t and an up issued in cycle t+1 would reach the output register on the same edge.
  - State bit down_last = a down was accepted last cycle.
  - up_block = down_last.
- Arbitration:
  - rr_ptr (clog2 NUM_REQ bits) marks the highest-priority requester.
  - Candidate c = first requester with req_valid set, scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - If no candidate, there is no grant.
  - If c is an up request and up_block is set, there is no grant this cycle (bubble). rr_ptr is unchanged, so c wins next cycle because down_last clears.
  - Otherwise req_ready[c] = 1.
  - On acceptance, rr_ptr ← (c+1) mod NUM_REQ and issue_count increments.
- Requesters are never skipped. A blocked up costs exactly one bubble.
- Functional definition, up: out bit j = OR of in bits k where k is a subset of j (k & ~j == 0).
- Functional definition, down: out bit j = OR of in bits k where k is a superset of j.
- busy = OR of all tag-pipeline valid bits and out_valid.

## Timing
- Handshake at edge T:
  - Up result: out_valid high in the cycle after edge T+1 (2-cycle latency).
  - Down result: out_valid high in the cycle after edge T+2 (3-cycle latency).
- Throughput: one request per cycle, except one bubble for an up whose turn immediately follows a down acceptance.
- Reset values, applied immediately on rst assertion:
  - out_valid, out_id, out_dir, out_data, busy, issue_count, rr_ptr, down_last: all 0.
  - All tag-pipeline valid bits: 0.
  - req_ready: 0 while rst is high.
- Reset mid-flight: all in-flight results are dropped with no out_valid pulse. The core data registers need no reset.
- A requester may change req_dir or req_data freely while not granted. Values are sampled only on its acceptance edge.
- Same-cycle events:
  - A result emerging and a new acceptance in the same cycle are independent.
  - A grant is never withheld for output occupancy other than the up_block rule.

## Test plan
- Single up, bit 0 set: requester 1, req_data = 128'h1, dir 0 → out_valid 2 cycles after handshake, out_id 1, out_data = all ones; issue_count = 1.
- Single down, bit 0 set: requester 2, req_data = 128'h1, dir 1 → out_valid 3 cycles after handshake, out_data = 128'h1. The same request with bit 127 set gives all ones.
- Up, bit 5 set: in = 1<<5, dir 0 → out_data has exactly 32 bits set, all indices j with j & 5 == 5; bit 0 clear, bit 127 set.
- Down then up: requester 0 down (1<<127) and requester 1 up (1<<0), both valid from cycle 0.
  - Grant 0 at cycle 0, bubble at cycle 1, grant 1 at cycle 2.
  - Results appear on consecutive cycles (down first, then up) with no overlap.
- All four requesters continuously valid, dirs {1,0,1,0} → grant order 0, bubble, 1, 2, bubble, 3, 0, …; every out_id appears once per rotation; no requester starves over 100 cycles.
- Reset mid-flight: issue a down and an up, assert rst one cycle later for 2 cycles → no out_valid pulse; busy = 0, issue_count = 0, rr_ptr = 0 afterwards; the next request behaves as in the first scenario.
